ps2_key_tracker: RTL and testbench

- Converts the PS/2 scan-code byte stream (set 2) from the PS/2 byte receiver into a held-key bitmap, `key_down[511:0]`.
- This bitmap is the vector that the game-side key decoder pulses and gates by game state.
- Bitmap index is {extended, code[7:0]}. Make codes set the bit, break codes clear it.
- Also reports the most recent changed key with a one-cycle strobe.

---
 rtl/ps2_key_tracker_pkg.sv | 51 +++++
 rtl/ps2_key_tracker_if.sv | 21 ++
 rtl/ps2_gap_timer.sv | 33 +++
 rtl/ps2_key_tracker.sv | 139 +++++++++++++
 tb/tb_ps2_key_tracker.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/ps2_key_tracker_pkg.sv
// Shared PS/2 scan-code set 2 constants, tracker state encoding and key index
// constants used by the game-side key decoder.
package ps2_key_tracker_pkg;

    localparam int KEY_IDX_W = 9;
    localparam int KEY_COUNT = 512;

    localparam logic [7:0] SC_EXT        = 8'hE0;
    localparam logic [7:0] SC_BRK        = 8'hF0;
    localparam logic [7:0] SC_PAUSE      = 8'hE1;
    localparam logic [7:0] SC_FAKE_SHIFT = 8'h12;

    localparam logic [7:0] SC_BAT_OK = 8'hAA;
    localparam logic [7:0] SC_ACK    = 8'hFA;
    localparam logic [7:0] SC_RESEND = 8'hFE;
    localparam logic [7:0] SC_ECHO   = 8'hEE;
    localparam logic [7:0] SC_ERR_LO = 8'h00;
    localparam logic [7:0] SC_ERR_HI = 8'hFF;

    // Bitmap indices {extended, code} the key decoder gates by game state.
    localparam logic [KEY_IDX_W-1:0] KEY_W     = 9'h01D;
    localparam logic [KEY_IDX_W-1:0] KEY_A     = 9'h01C;
    localparam logic [KEY_IDX_W-1:0] KEY_S     = 9'h01B;
    localparam logic [KEY_IDX_W-1:0] KEY_D     = 9'h023;
    localparam logic [KEY_IDX_W-1:0] KEY_SPACE = 9'h029;
    localparam logic [KEY_IDX_W-1:0] KEY_ENTER = 9'h05A;
    localparam logic [KEY_IDX_W-1:0] KEY_ESC   = 9'h076;
    localparam logic [KEY_IDX_W-1:0] KEY_UP    = 9'h175;
    localparam logic [KEY_IDX_W-1:0] KEY_DOWN  = 9'h172;
    localparam logic [KEY_IDX_W-1:0] KEY_LEFT  = 9'h16B;
    localparam logic [KEY_IDX_W-1:0] KEY_RIGHT = 9'h174;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_EXT     = 3'd1,
        ST_BRK     = 3'd2,
        ST_EXT_BRK = 3'd3,
        ST_PAUSE   = 3'd4
    } tracker_state_t;

    // Keyboard status/response bytes that never form part of a key sequence.
    function automatic logic is_ignored(input logic [7:0] code);
        return (code == SC_BAT_OK) || (code == SC_ACK) || (code == SC_RESEND) ||
               (code == SC_ECHO) || (code == SC_ERR_LO) || (code == SC_ERR_HI);
    endfunction

    function automatic logic [KEY_IDX_W-1:0] key_index(input logic ext, input logic [7:0] code);
        return {ext, code};
    endfunction

endpackage

// File: rtl/ps2_key_tracker_if.sv
// Byte-receiver to key-tracker bus: incoming scan bytes and control strobes,
// outgoing held-key bitmap with change strobe.
interface ps2_key_tracker_if;
    logic [7:0]   rx_byte;
    logic         rx_valid;
    logic         rx_err;
    logic         clear;
    logic [511:0] key_down;
    logic [8:0]   last_change;
    logic         key_valid;

    modport master (
        output rx_byte, rx_valid, rx_err, clear,
        input  key_down, last_change, key_valid
    );

    modport slave (
        input  rx_byte, rx_valid, rx_err, clear,
        output key_down, last_change, key_valid
    );
endinterface

// File: rtl/ps2_gap_timer.sv
// Inter-byte gap timer: reloaded by every byte, fires once when a multi-byte
// sequence has stalled for TIMEOUT cycles.
module ps2_gap_timer #(
    parameter int TIMEOUT = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic kick,
    input  logic enable,
    input  logic flush,
    output logic expired
);

    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    logic [CNT_W-1:0] remain;

    // Leaving IDLE always coincides with a kick, so the count is loaded before it matters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            remain <= '0;
        end else if (flush) begin
            remain <= '0;
        end else if (kick) begin
            remain <= CNT_W'(TIMEOUT - 1);
        end else if (enable && (remain != '0)) begin
            remain <= remain - CNT_W'(1);
        end
    end

    assign expired = enable && !kick && !flush && (remain == '0);

endmodule

// File: rtl/ps2_key_tracker.sv
// PS/2 set-2 scan-code parser maintaining a 512-bit held-key bitmap.
// Define PS2_TYPEMATIC_FILTER_EN to suppress key_valid on typematic repeats.
module ps2_key_tracker
    import ps2_key_tracker_pkg::*;
#(
    parameter int TIMEOUT   = 1_000_000,
    parameter int PAUSE_LEN = 8
) (
    input logic               clk,
    input logic               rst_n,
    ps2_key_tracker_if.slave  bus
);

    localparam int PAUSE_W = $clog2(PAUSE_LEN + 1);

    tracker_state_t       state;
    tracker_state_t       state_next;
    logic [PAUSE_W-1:0]   pause_cnt;
    logic [PAUSE_W-1:0]   pause_next;
    logic                 gap_expired;
    logic                 key_hit;
    logic                 key_make;
    logic [KEY_IDX_W-1:0] key_idx;
    logic                 make_fresh;
    logic [511:0]         key_down_q;
    logic [8:0]           last_change_q;
    logic                 key_valid_q;

    ps2_gap_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_gap_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .kick    (bus.rx_valid),
        .enable  (state != ST_IDLE),
        .flush   (bus.rx_err || bus.clear),
        .expired (gap_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            pause_cnt <= '0;
        end else begin
            state     <= state_next;
            pause_cnt <= pause_next;
        end
    end

    // Receiver errors and clear abort before any byte is parsed; the timer never fires on a kick cycle.
    always_comb begin
        state_next = state;
        pause_next = pause_cnt;
        key_hit    = 1'b0;
        key_make   = 1'b0;
        key_idx    = key_index(1'b0, bus.rx_byte);
        if (bus.rx_err || bus.clear || gap_expired) begin
            state_next = ST_IDLE;
            pause_next = '0;
        end else if (bus.rx_valid) begin
            case (state)
                ST_IDLE: begin
                    if (bus.rx_byte == SC_EXT) begin
                        state_next = ST_EXT;
                    end else if (bus.rx_byte == SC_BRK) begin
                        state_next = ST_BRK;
                    end else if (bus.rx_byte == SC_PAUSE) begin
                        state_next = ST_PAUSE;
                        pause_next = PAUSE_W'(PAUSE_LEN - 1);
                    end else if (!is_ignored(bus.rx_byte)) begin
                        key_hit  = 1'b1;
                        key_make = 1'b1;
                    end
                end
                ST_EXT: begin
                    key_idx = key_index(1'b1, bus.rx_byte);
                    if (bus.rx_byte == SC_BRK) begin
                        state_next = ST_EXT_BRK;
                    end else begin
                        state_next = ST_IDLE;
                        key_hit    = (bus.rx_byte != SC_FAKE_SHIFT);
                        key_make   = 1'b1;
                    end
                end
                ST_BRK: begin
                    state_next = ST_IDLE;
                    key_hit    = 1'b1;
                end
                ST_EXT_BRK: begin
                    key_idx    = key_index(1'b1, bus.rx_byte);
                    state_next = ST_IDLE;
                    key_hit    = (bus.rx_byte != SC_FAKE_SHIFT);
                end
                ST_PAUSE: begin
                    pause_next = pause_cnt - PAUSE_W'(1);
                    if (pause_cnt <= PAUSE_W'(1)) begin
                        state_next = ST_IDLE;
                        pause_next = '0;
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                    pause_next = '0;
                end
            endcase
        end
    end

`ifdef PS2_TYPEMATIC_FILTER_EN
    assign make_fresh = !key_down_q[key_idx];
`else
    assign make_fresh = 1'b1;
`endif

    // A repeat make still rewrites the bit, so the bitmap is identical in both builds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_down_q    <= '0;
            last_change_q <= '0;
            key_valid_q   <= 1'b0;
        end else begin
            key_valid_q <= 1'b0;
            if (bus.clear) begin
                key_down_q <= '0;
            end else if (key_hit) begin
                key_down_q[key_idx] <= key_make;
                if (!key_make || make_fresh) begin
                    last_change_q <= key_idx;
                    key_valid_q   <= 1'b1;
                end
            end
        end
    end

    assign bus.key_down    = key_down_q;
    assign bus.last_change = last_change_q;
    assign bus.key_valid   = key_valid_q;

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Randomized self-checking bench for ps2_key_tracker against a flag/queue-level
// reference model of scan-code set 2 make/break parsing.
module tb_ps2_key_tracker;

    localparam int TIMEOUT   = 40;
    localparam int PAUSE_LEN = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    ps2_key_tracker_if bus ();

    ps2_key_tracker #(
        .TIMEOUT   (TIMEOUT),
        .PAUSE_LEN (PAUSE_LEN)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    longint edge_num = 0;
    always @(posedge clk) edge_num <= edge_num + 1;

    int errors = 0;
    int checks = 0;
    int valid_seen = 0;

    logic [511:0] m_keys;
    logic [8:0]   m_last;
    bit           m_ext;
    bit           m_brk;
    int           m_pause;
    longint       m_last_edge;

    task automatic check_output(input string tag, input logic [511:0] got, input logic [511:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit tb_ignored(input logic [7:0] b);
        return b inside {8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF};
    endfunction

    task automatic model_drop_sequence();
        m_ext   = 1'b0;
        m_brk   = 1'b0;
        m_pause = 0;
    endtask

    task automatic model_key(input bit ext, input logic [7:0] c, input bit make, output bit v);
        logic [8:0] idx;
        idx = {ext, c};
        v = 1'b1;
`ifdef PS2_TYPEMATIC_FILTER_EN
        if (make && m_keys[idx]) v = 1'b0;
`endif
        m_keys[idx] = make;
        if (v) m_last = idx;
    endtask

    // Prefix flags: E0 seen, F0 seen, pause bytes still to skip.
    task automatic model_byte(input logic [7:0] b, output bit v);
        v = 1'b0;
        if ((m_ext || m_brk || m_pause > 0) && (edge_num - m_last_edge) > TIMEOUT)
            model_drop_sequence();
        m_last_edge = edge_num;
        if (m_pause > 0) begin
            m_pause--;
        end else if (m_brk) begin
            if (!(m_ext && b == 8'h12)) model_key(m_ext, b, 1'b0, v);
            model_drop_sequence();
        end else if (m_ext) begin
            if (b == 8'hF0) begin
                m_brk = 1'b1;
            end else begin
                if (b != 8'h12) model_key(1'b1, b, 1'b1, v);
                model_drop_sequence();
            end
        end else if (b == 8'hE0) begin
            m_ext = 1'b1;
        end else if (b == 8'hF0) begin
            m_brk = 1'b1;
        end else if (b == 8'hE1) begin
            m_pause = PAUSE_LEN - 1;
        end else if (!tb_ignored(b)) begin
            model_key(1'b0, b, 1'b1, v);
        end
    endtask

    // Drives one cycle at a negedge, then checks the registered outputs one cycle later.
    task automatic apply_stimulus(input logic [7:0] b, input bit v, input bit err, input bit clr);
        bit exp_v;
        exp_v = 1'b0;
        bus.rx_byte  = b;
        bus.rx_valid = v;
        bus.rx_err   = err;
        bus.clear    = clr;
        if (clr) begin
            m_keys = '0;
            model_drop_sequence();
        end else if (err) begin
            model_drop_sequence();
        end else if (v) begin
            model_byte(b, exp_v);
        end
        @(posedge clk);
        @(negedge clk);
        bus.rx_valid = 1'b0;
        bus.rx_err   = 1'b0;
        bus.clear    = 1'b0;
        if (bus.key_valid) valid_seen++;
        check_output("key_valid", 512'(bus.key_valid), 512'(exp_v));
        check_output("last_change", 512'(bus.last_change), 512'(m_last));
        check_output("key_down", bus.key_down, m_keys);
    endtask

    task automatic send(input logic [7:0] b);
        apply_stimulus(b, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic idle(input int n);
        if (n > 0) begin
            @(negedge clk);
            check_output("strobe_len", 512'(bus.key_valid), 512'(0));
            repeat (n - 1) @(negedge clk);
        end
    endtask

    function automatic logic [7:0] pick_byte();
        logic [7:0] codes [10];
        logic [7:0] ign [6];
        int r;
        codes = '{8'h1C, 8'h1D, 8'h1B, 8'h23, 8'h29, 8'h5A, 8'h75, 8'h6B, 8'h74, 8'h72};
        ign   = '{8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF};
        r = $urandom_range(0, 99);
        if (r < 20) return 8'hE0;
        if (r < 35) return 8'hF0;
        if (r < 39) return 8'hE1;
        if (r < 44) return 8'h12;
        if (r < 49) return ign[$urandom_range(0, 5)];
        if (r < 52) return 8'($urandom_range(0, 255));
        return codes[$urandom_range(0, 9)];
    endfunction

    initial begin
        int exp_cnt;
        int r;
        bus.rx_byte  = 8'h00;
        bus.rx_valid = 1'b0;
        bus.rx_err   = 1'b0;
        bus.clear    = 1'b0;
        m_keys = '0;
        m_last = '0;
        m_last_edge = 0;
        model_drop_sequence();

        repeat (3) @(negedge clk);
        check_output("rst_key_down", bus.key_down, '0);
        check_output("rst_last", 512'(bus.last_change), 512'(0));
        check_output("rst_valid", 512'(bus.key_valid), 512'(0));
        rst_n = 1'b1;
        idle(2);

        send(8'h1C);
        check_output("make_1c_bit", 512'(bus.key_down[9'h01C]), 512'(1));
        idle(3);

        send(8'hE0); send(8'h75);
        check_output("ext_make_175", 512'(bus.key_down[9'h175]), 512'(1));
        send(8'hE0); send(8'hF0); send(8'h75);
        check_output("ext_brk_175", 512'(bus.key_down[9'h175]), 512'(0));
        check_output("no_075", 512'(bus.key_down[9'h075]), 512'(0));
        idle(2);

        apply_stimulus(8'h00, 1'b0, 1'b0, 1'b1);
        send(8'hE0);
        idle(TIMEOUT + 2);
        send(8'h1C);
        check_output("timeout_01c", 512'(bus.key_down[9'h01C]), 512'(1));
        check_output("timeout_11c", 512'(bus.key_down[9'h11C]), 512'(0));
        idle(2);

        apply_stimulus(8'h00, 1'b0, 1'b0, 1'b1);
        valid_seen = 0;
        send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
        send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
        send(8'h29);
        check_output("pause_valids", 512'(valid_seen), 512'(1));
        check_output("pause_014", 512'(bus.key_down[9'h014]), 512'(0));
        check_output("pause_077", 512'(bus.key_down[9'h077]), 512'(0));
        idle(2);

        send(8'h1C); send(8'h6B);
        apply_stimulus(8'hF0, 1'b1, 1'b1, 1'b0);
        send(8'h1C);
        check_output("err_1c_held", 512'(bus.key_down[9'h01C]), 512'(1));
        apply_stimulus(8'h00, 1'b0, 1'b0, 1'b1);
        check_output("clear_all", bus.key_down, '0);
        idle(2);

        valid_seen = 0;
        send(8'h1C); send(8'h1C); send(8'h1C);
`ifdef PS2_TYPEMATIC_FILTER_EN
        exp_cnt = 1;
`else
        exp_cnt = 3;
`endif
        check_output("repeat_valids", 512'(valid_seen), 512'(exp_cnt));
        check_output("repeat_bit", 512'(bus.key_down[9'h01C]), 512'(1));

        send(8'hE0); send(8'hF0);
        #2 rst_n = 1'b0;
        #1;
        check_output("async_key_down", bus.key_down, '0);
        check_output("async_last", 512'(bus.last_change), 512'(0));
        check_output("async_valid", 512'(bus.key_valid), 512'(0));
        m_keys = '0;
        m_last = '0;
        model_drop_sequence();
        @(negedge clk);
        rst_n = 1'b1;
        send(8'h1C);
        check_output("post_rst_01c", 512'(bus.key_down[9'h01C]), 512'(1));

        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 99);
            if (r < 70)      idle($urandom_range(0, 3));
            else if (r < 95) idle($urandom_range(4, TIMEOUT / 2));
            else             idle($urandom_range(TIMEOUT + 5, TIMEOUT + 20));
            r = $urandom_range(0, 99);
            if (r < 2)       apply_stimulus(8'h00, 1'b0, 1'b1, 1'b0);
            else if (r < 4)  apply_stimulus(8'h00, 1'b0, 1'b0, 1'b1);
            else if (r < 6)  apply_stimulus(pick_byte(), 1'b1, 1'b1, 1'b0);
            else if (r < 7)  apply_stimulus(pick_byte(), 1'b1, 1'b0, 1'b1);
            else             send(pick_byte());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
